// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus the valid/ready stream seen by the reader.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   modport master (
      input  fifo_empty, fifo_rd_data, m_ready,
      output fifo_rd_en, m_valid, m_data
   );
   modport slave (
      output fifo_empty, fifo_rd_data, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   fifo_stream_reader_if.master bus,
   output logic [CNT_WIDTH-1:0] xfer_count
);
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  head;
   logic                  inflight;
   logic [1:0]            cnt;
   logic                  pop;
   logic [2:0]            occ;
   // occ is both the read-issue guard and the next occupancy, since a capture always follows an in-flight read
   always_comb begin
      bus.m_valid    = cnt != 2'd0;
      bus.m_data     = mem[head];
      pop            = bus.m_valid && bus.m_ready && !flush;
      occ            = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
      bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush && occ < 3'd2;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         head       <= 1'b0;
         cnt        <= 2'd0;
         inflight   <= 1'b0;
         xfer_count <= '0;
      end else if (flush) begin
         cnt      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         if (inflight) mem[head ^ cnt[0]] <= bus.fifo_rd_data;
         head       <= head ^ pop;
         cnt        <= occ[1:0];
         inflight   <= bus.fifo_rd_en;
         xfer_count <= xfer_count + CNT_WIDTH'(pop);
      end
   end
endmodule
